bus_arbiter_rr: RTL

Parametrised N-master to 1-slave bus arbiter for the SOPC bus protocol (address/read/write/mask/data_wr out, stall/data_rd/data_rd_2 back). It sits between CPU instruction fetch, CPU data port and further masters (DMA, graphics refill) and the shared address-decoded slave bus. It adds zero cycles when uncontended. It holds a grant for the whole stalled transaction. Arbitration is round-robin or fixed-priority.

---
 rtl/bus_arbiter_rr_if.sv | 43 ++++
 rtl/bus_arbiter_rr.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr_if.sv
// Bus bundle for the N-master to 1-slave arbiter: per-master request/return
// lanes plus the single downstream slave bus.
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 2
);
    logic [N_MASTERS-1:0][31:0] m_address;
    logic [N_MASTERS-1:0]       m_read;
    logic [N_MASTERS-1:0]       m_write;
    logic [N_MASTERS-1:0][31:0] m_data_wr;
    logic [N_MASTERS-1:0][3:0]  m_mask;
    logic [N_MASTERS-1:0]       m_stall;
    logic [N_MASTERS-1:0][31:0] m_data_rd;
    logic [N_MASTERS-1:0][31:0] m_data_rd_2;

    logic [31:0] s_address;
    logic [31:0] s_data_wr;
    logic [3:0]  s_mask;
    logic        s_read;
    logic        s_write;
    logic        s_stall;
    logic [31:0] s_data_rd;
    logic [31:0] s_data_rd_2;

    // Handshake: a master presents a request (m_read or m_write) and holds it
    // stable until a cycle where its m_stall is 0; that cycle completes the
    // access. The downstream side behaves the same with s_read/s_write/s_stall.

    // slave: the arbiter's view (it serves the masters and drives the slave bus)
    modport slave (
        input  m_address, m_read, m_write, m_data_wr, m_mask,
        output m_stall, m_data_rd, m_data_rd_2,
        output s_address, s_data_wr, s_mask, s_read, s_write,
        input  s_stall, s_data_rd, s_data_rd_2
    );

    // master: the environment's view (requesting masters plus the downstream slave)
    modport master (
        output m_address, m_read, m_write, m_data_wr, m_mask,
        input  m_stall, m_data_rd, m_data_rd_2,
        input  s_address, s_data_wr, s_mask, s_read, s_write,
        output s_stall, s_data_rd, s_data_rd_2
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-master to 1-slave SOPC bus arbiter, round-robin or fixed priority, with a
// grant lock held across stalled transactions and zero added latency.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 2,
    parameter int MODE      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_arbiter_rr_if.slave      bus,
    output logic [N_MASTERS-1:0] grant,
    output logic                 busy,
    output logic                 state_dbg
);
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_MASTERS-1:0] req;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    int                 idx;

    assign busy      = (state_q == LOCKED);
    assign state_dbg = state_q;

    // Winner selection. Round-robin scans from the farthest candidate back to
    // last+1 so the nearest requester after last overwrites the others.
    always_comb begin
        req       = bus.m_read | bus.m_write;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (state_q == LOCKED) begin
            win_valid = req[owner_q];
            win_idx   = owner_q;
        end else if (MODE == 1) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int k = N_MASTERS; k >= 1; k--) begin
                idx = int'(last_q) + k;
                if (idx >= N_MASTERS) idx = idx - N_MASTERS;
                if (req[idx]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        grant           = '0;
        bus.s_address   = '0;
        bus.s_data_wr   = '0;
        bus.s_mask      = '0;
        bus.s_read      = 1'b0;
        bus.s_write     = 1'b0;
        bus.m_stall     = '0;
        bus.m_data_rd   = '0;
        bus.m_data_rd_2 = '0;
        if (win_valid) begin
            grant[win_idx] = 1'b1;
            bus.s_address  = bus.m_address[win_idx];
            bus.s_data_wr  = bus.m_data_wr[win_idx];
            bus.s_mask     = bus.m_mask[win_idx];
            bus.s_read     = bus.m_read[win_idx];
            bus.s_write    = bus.m_write[win_idx];
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win_valid && (win_idx == IDX_W'(i))) begin
                bus.m_stall[i]     = bus.s_stall;
                bus.m_data_rd[i]   = bus.s_data_rd;
                bus.m_data_rd_2[i] = bus.s_data_rd_2;
            end else begin
                bus.m_stall[i] = req[i];
            end
        end
    end

    // An owner that drops its request while locked aborts: back to IDLE and
    // last stays put, since nothing completed.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    if (bus.s_stall) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end else if (MODE == 0) begin
                        last_d = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (!win_valid) begin
                    state_d = IDLE;
                end else if (!bus.s_stall) begin
                    state_d = IDLE;
                    if (MODE == 0) last_d = win_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule
